// File: rtl/sipo_receiver.sv
// Serial-in parallel-out frame receiver: LSB-first frames of WIDTH bits framed by a start strobe,
// with a valid/ack handshake on the assembled word, a sticky overrun flag and an abort pulse.
module sipo_receiver #(
   parameter int unsigned WIDTH = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             serial_in,
   input  logic             word_ack,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic             busy,
   output logic             overrun,
   output logic             frame_error
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   typedef enum logic {StIdle, StShift} state_e;

   state_e           state_q, state_d;
   logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             ferr_q, ferr_d;
   logic             complete;

   // Bit 0 of the shift register never reaches the word: the final bit bypasses it.
   logic unused_shift_lsb;
   assign unused_shift_lsb = shift_q[0];

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      word_d    = word_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      ferr_d    = 1'b0;
      complete  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StShift;
               bit_cnt_d = CntW'(1);
               shift_d   = {serial_in, {(WIDTH - 1){1'b0}}};
            end
         end
         StShift: begin
            if (start) begin
               // Early start aborts the current frame and begins a new one on this bit.
               ferr_d    = 1'b1;
               bit_cnt_d = CntW'(1);
               shift_d   = {serial_in, {(WIDTH - 1){1'b0}}};
            end else if (bit_cnt_q == CntLast) begin
               complete  = 1'b1;
               state_d   = StIdle;
               bit_cnt_d = '0;
               word_d    = {serial_in, shift_q[WIDTH-1:1]};
            end else begin
               shift_d   = {serial_in, shift_q[WIDTH-1:1]};
               bit_cnt_d = bit_cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      if (complete) begin
         valid_d = 1'b1;
         if (valid_q && !word_ack) overrun_d = 1'b1;
      end else if (word_ack) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         word_q    <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         word_q    <= word_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         ferr_q    <= ferr_d;
      end
   end

   assign word_out    = word_q;
   assign word_valid  = valid_q;
   assign busy        = (state_q == StShift);
   assign overrun     = overrun_q;
   assign frame_error = ferr_q;

endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver: frames are driven LSB first, expected words go through a
// scoreboard queue and are compared when the final bit of each frame has been clocked in.
module tb_sipo_receiver;

   logic        clk;
   logic        rst;
   logic        start;
   logic        serial_in;
   logic        word_ack;
   logic [11:0] word_out;
   logic        word_valid;
   logic        busy;
   logic        overrun;
   logic        frame_error;

   int checks = 0;
   int errors = 0;
   logic [11:0] sb_q[$];

   sipo_receiver #(.WIDTH(12)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .serial_in  (serial_in),
      .word_ack   (word_ack),
      .word_out   (word_out),
      .word_valid (word_valid),
      .busy       (busy),
      .overrun    (overrun),
      .frame_error(frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".word_out"}, 32'(word_out), 32'h0);
      chk({tag, ".word_valid"}, 32'(word_valid), 32'h0);
      chk({tag, ".busy"}, 32'(busy), 32'h0);
      chk({tag, ".overrun"}, 32'(overrun), 32'h0);
      chk({tag, ".frame_error"}, 32'(frame_error), 32'h0);
   endtask

   // Drive inputs, take one rising edge, then settle 1 time unit before sampling.
   task automatic step(input logic st, input logic si, input logic ack);
      start     = st;
      serial_in = si;
      word_ack  = ack;
      @(posedge clk);
      #1;
      start     = 1'b0;
      serial_in = 1'b0;
      word_ack  = 1'b0;
   endtask

   task automatic send_frame(input string tag, input logic [11:0] w, input logic ack_first,
                             input logic ack_last, input logic ferr_first);
      logic [11:0] exp_w;
      sb_q.push_back(w);
      for (int i = 0; i < 12; i++) begin
         step(i == 0, w[i], (i == 0) ? ack_first : ((i == 11) ? ack_last : 1'b0));
         chk($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'(i < 11));
         chk($sformatf("%s.ferr[%0d]", tag, i), 32'(frame_error),
             32'((i == 0) ? ferr_first : 1'b0));
      end
      exp_w = sb_q.pop_front();
      chk({tag, ".word_out"}, 32'(word_out), 32'(exp_w));
      chk({tag, ".word_valid"}, 32'(word_valid), 32'h1);
   endtask

   task automatic do_ack(input string tag);
      step(1'b0, 1'b0, 1'b1);
      chk({tag, ".valid_after_ack"}, 32'(word_valid), 32'h0);
   endtask

   task automatic pulse_reset(input string tag);
      #2 rst = 1'b1;
      #1 chk_all_zero(tag);
      #1 rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      serial_in = 1'b0;
      word_ack  = 1'b0;
      #1;
      chk_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Idle line with start low must not start reception.
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("idle.busy", 32'(busy), 32'h0);

      // Single frame.
      send_frame("a5c", 12'hA5C, 1'b0, 1'b0, 1'b0);
      chk("a5c.overrun", 32'(overrun), 32'h0);
      do_ack("a5c");

      // Back-to-back frames, ack one cycle after each valid.
      send_frame("b2b1", 12'h123, 1'b0, 1'b0, 1'b0);
      send_frame("b2b2", 12'hFED, 1'b1, 1'b0, 1'b0);
      do_ack("b2b2");
      chk("b2b.overrun", 32'(overrun), 32'h0);
      chk("b2b.ferr", 32'(frame_error), 32'h0);

      // Early start at bit 5 of 12'hFFF.
      for (int i = 0; i < 5; i++) begin
         step(i == 0, 1'b1, 1'b0);
         chk($sformatf("early.valid[%0d]", i), 32'(word_valid), 32'h0);
      end
      send_frame("early", 12'h0F0, 1'b0, 1'b0, 1'b1);
      chk("early.overrun", 32'(overrun), 32'h0);
      do_ack("early");

      // Overrun: two frames without ack.
      send_frame("ovr1", 12'h001, 1'b0, 1'b0, 1'b0);
      chk("ovr1.overrun", 32'(overrun), 32'h0);
      send_frame("ovr2", 12'h002, 1'b0, 1'b0, 1'b0);
      chk("ovr2.overrun", 32'(overrun), 32'h1);
      do_ack("ovr");
      chk("ovr.overrun_sticky", 32'(overrun), 32'h1);
      chk("ovr.word_held", 32'(word_out), 32'h002);
      step(1'b0, 1'b0, 1'b0);
      chk("ovr.overrun_still", 32'(overrun), 32'h1);

      pulse_reset("rst_clear");

      // Ack on the completion edge of the second frame.
      send_frame("col1", 12'h5A5, 1'b0, 1'b0, 1'b0);
      send_frame("col2", 12'h3C3, 1'b0, 1'b1, 1'b0);
      chk("col.overrun", 32'(overrun), 32'h0);
      do_ack("col");

      // Async reset between edges at bit 7.
      for (int i = 0; i < 7; i++) step(i == 0, 1'b1, 1'b0);
      chk("arst.busy_before", 32'(busy), 32'h1);
      pulse_reset("arst");
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         chk($sformatf("arst.idle_busy[%0d]", i), 32'(busy), 32'h0);
      end
      chk("arst.valid_idle", 32'(word_valid), 32'h0);
      send_frame("arst555", 12'h555, 1'b0, 1'b0, 1'b0);
      chk("arst.overrun", 32'(overrun), 32'h0);
      chk("sb.empty", 32'(sb_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sipo_receiver.md
SIPO_RECEIVER -- requirements
Module: sipo_receiver

Interface
REQ-001 Parameter WIDTH, default 12, is the frame length in bits and the width of the assembled word.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  frame sync; high for exactly the cycle in which serial_in carries bit 0 of a frame.
REQ-005 serial_in  input  1  serial data, LSB first, one bit per clock.
REQ-006 word_ack  input  1  consumer acknowledge; clears word_valid.
REQ-007 word_out  output  WIDTH  last completed word; held between completions.
REQ-008 word_valid  output  1  word_out holds an unacknowledged word.
REQ-009 busy  output  1  frame reception in progress (state SHIFT).
REQ-010 overrun  output  1  sticky; a completed word overwrote an unacknowledged one.
REQ-011 frame_error  output  1  one-cycle pulse; a frame was aborted by an early start.

Function
REQ-012 The block SHALL have two states, IDLE and SHIFT, a bit counter bit_cnt (0..WIDTH-1) and a WIDTH-bit shift register.
REQ-013 IDLE, start=1 at edge E0: SHALL capture serial_in as bit 0, set bit_cnt=1 and enter SHIFT; start=0 leaves the block in IDLE with serial_in ignored.
REQ-014 SHIFT, start=0: each edge SHALL shift right, insert serial_in at the MSB and increment bit_cnt.
REQ-015 The edge that samples bit WIDTH-1 (E0+WIDTH-1) SHALL load word_out with {serial_in, shift[WIDTH-1:1]} (bit 0 at LSB), set word_valid, clear bit_cnt and return to IDLE.
REQ-016 Latency: word_valid is high in the cycle after edge E0+WIDTH-1, matching a 12-bit LSB-first PISO source loaded with the same word.
REQ-017 Back-to-back: start=1 on the cycle immediately after the last bit of a frame SHALL begin a new frame with no lost bit.
REQ-018 SHIFT, start=1 (any bit_cnt including WIDTH-1): the current frame SHALL be discarded with word_out and word_valid unchanged, frame_error pulsed for one cycle, serial_in taken as bit 0 of a new frame and bit_cnt=1.
REQ-019 word_valid SHALL clear on an edge with word_ack=1 and no completion on that edge; word_ack while word_valid=0 has no effect.
REQ-020 A completion while word_valid=1 and word_ack=0 SHALL overwrite word_out, keep word_valid=1 and set overrun.
REQ-021 A completion on the same edge as word_ack=1 SHALL load the new word with word_valid=1 and SHALL NOT set overrun.
REQ-022 overrun SHALL clear only on reset.
REQ-023 busy SHALL equal (state==SHIFT).

Reset
REQ-024 rst=1 SHALL immediately force IDLE, bit_cnt=0, shift register=0, word_out=0, word_valid=0, busy=0, overrun=0 and frame_error=0, independent of clk.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release, reception resumes only on the next start=1.

Verification
REQ-026 Single frame: start with bits of 12'hA5C, LSB first -> word_out=12'hA5C, word_valid high one cycle after the 12th bit, busy high for the 11 cycles after the start edge.
REQ-027 Back-to-back: frames 12'h123 then 12'hFED with no gap, word_ack one cycle after each valid -> both words delivered, overrun=0, frame_error=0.
REQ-028 Early start: start again at bit 5 of frame 12'hFFF, then a full 12'h0F0 -> one frame_error pulse, and the only completed word is 12'h0F0.
REQ-029 Overrun: two frames 12'h001 then 12'h002 with no word_ack -> word_out=12'h002, word_valid=1, overrun=1; word_ack then clears word_valid only.
REQ-030 Ack collision: word_ack on the completion edge of a second frame 12'h3C3 -> word_out=12'h3C3, word_valid=1, overrun=0.
REQ-031 Async reset: rst pulsed between edges at bit 7 -> all outputs 0 at once; the next complete frame 12'h555 is received correctly.
